adc_result_framer: RTL and testbench
====================================

Name: adc_result_framer

Overview:
Downstream consumer of the dual-channel ADC acquisition stage. It captures each averaged result pair on the one-cycle completion strobe and serializes it into a fixed 10-byte frame on a valid/ready byte stream feeding the UART transmitter. A one-deep pending buffer absorbs a result that arrives while a frame is in flight. A sticky overrun flag records any result that had to be dropped.

Parameters:
DATA_WIDTH, 18, width of each channel result; legal range 1..24; zero-extended to 24 bits in the frame
HEADER_BYTE, 8'hA5, frame start marker

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
result_valid  in  1  one-cycle completion strobe from acquisition stage; every cycle it is high counts as one capture
result_diap  in  1  range-measurement flag accompanying the result
data_in_1  in  DATA_WIDTH  channel 1 result, valid while result_valid is high
data_in_2  in  DATA_WIDTH  channel 2 result, valid while result_valid is high
overrun_clr  in  1  clears the sticky overrun flag
tx_data  out  8  current frame byte
tx_valid  out  1  tx_data is valid
tx_ready  in  1  sink accepts the byte
busy  out  1  high in any state except IDLE, or when pending is full
overrun  out  1  sticky flag: a result was dropped

Behaviour:
- Reset values: tx_data=0, tx_valid=0, busy=0, overrun=0. Reset also sets seq=0, byte index=0, pending empty, state=IDLE.
- Reset mid-frame: tx_valid is low on the cycle after rst is sampled. The truncated frame is not resumed; the receiver resyncs on the header.
- Frame layout, byte 0 first, big-endian:
  - byte 0: HEADER_BYTE
  - byte 1: seq
  - bytes 2-4: ch1[23:0]
  - bytes 5-7: ch2[23:0]
  - byte 8: flags; bit0 = diap, bit1 = overrun value latched at LOAD, bits 7:2 = 0
  - byte 9: checksum = sum of bytes 1..8, modulo 256
- seq is 8 bits. It increments when byte 9 transfers and wraps 255 -> 0.
- Handshake:
  - A byte transfers on any cycle where tx_valid and tx_ready are both high.
  - tx_data is held stable while tx_valid is high and tx_ready is low.
  - tx_valid never drops mid-frame except on reset.
  - tx_ready is allowed high before tx_valid, with no combinational path from tx_ready to tx_valid.
- FSM states:
  - IDLE: tx_valid=0. If result_valid is high or pending is full, go to LOAD. A direct result_valid has priority over pending, but both cannot occur together.
  - LOAD: one cycle.
    - Latch ch1/ch2/diap from the capture source (direct inputs, or pending; pending is then freed).
    - Latch overrun into the flags byte, compute the checksum, set index=0.
    - Go to SEND.
  - SEND: tx_valid=1, tx_data=frame[index]. On transfer with index<9, index++. On transfer with index==9, increment seq; go to LOAD if pending is full, else IDLE.
- Latency: result_valid sampled in IDLE at edge N gives LOAD at N+1 and tx_valid=1 with the header at N+2. With tx_ready held high, one frame takes 10 cycles in SEND.
- Capture rules outside IDLE:
  - result_valid in LOAD or SEND with pending empty: store in pending.
  - Pending full: drop the new result and set overrun.
  - Same cycle pending is consumed (SEND->LOAD transition): the new result goes into pending, no overrun.
- overrun_clr: clears overrun. If a drop occurs in the same cycle, set wins.
- Zero-extension: bits 23:DATA_WIDTH of each channel field are 0.

Decomposition:
- Shared package adc_frame_pkg:
  - FRAME_LEN=10, HEADER_BYTE default
  - byte-index constants (IDX_SEQ=1, IDX_CH1=2, IDX_CH2=5, IDX_FLAGS=8, IDX_CSUM=9)
  - flag bit positions (FLAG_DIAP=0, FLAG_OVR=1)
  - state encoding
- No sub-module. The pending buffer and checksum are small enough to live inline.

Test Plan:
1. After reset, one result_valid with ch1=0x3FFFF, ch2=0x00001, diap=1, tx_ready=1 -> tx_valid rises 2 cycles later; bytes A5 00 03 FF FF 00 00 01 01 03; then IDLE and busy=0.
2. tx_ready toggled pseudo-randomly (about 30% high) during the same frame -> identical byte sequence, tx_data stable across every stall, no duplicated or skipped bytes.
3. Three results 3 cycles apart with tx_ready=1 -> first frame sent, second held in pending and sent back-to-back with seq=01 and no IDLE gap, third dropped; overrun=1; second frame's flags bit1=0; a later frame has flags bit1=1 until overrun_clr.
4. 256 consecutive frames -> seq runs 00..FF and the 257th frame carries seq=00; checksum verified on every frame.
5. rst asserted at byte 4 of a frame with pending full -> tx_valid=0 next cycle, pending cleared, next result produces a frame with seq=00.
6. result_valid on the exact cycle byte 9 transfers while pending is full -> pending frame sent next, new result retained in pending and sent after it, overrun stays 0.

Source files
------------

// File: rtl/adc_frame_pkg.sv
// Shared constants, state encoding and checksum helper for the ADC result framer.
package adc_frame_pkg;

  localparam int unsigned FRAME_LEN        = 10;
  localparam logic [7:0]  HEADER_BYTE_DFLT = 8'hA5;

  // Byte positions inside a frame (byte 0 goes out first).
  localparam logic [3:0] IDX_HDR   = 4'd0;
  localparam logic [3:0] IDX_SEQ   = 4'd1;
  localparam logic [3:0] IDX_CH1   = 4'd2;
  localparam logic [3:0] IDX_CH2   = 4'd5;
  localparam logic [3:0] IDX_FLAGS = 4'd8;
  localparam logic [3:0] IDX_CSUM  = 4'(FRAME_LEN - 1);

  // Bit positions inside the flags byte.
  localparam int unsigned FLAG_DIAP = 0;
  localparam int unsigned FLAG_OVR  = 1;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSend
  } state_e;

  // Modulo-256 sum of frame bytes 1..8.
  function automatic logic [7:0] frame_csum(input logic [7:0]  seq,
                                            input logic [23:0] ch1,
                                            input logic [23:0] ch2,
                                            input logic [7:0]  flags);
    logic [7:0] sum;
    sum = seq + ch1[23:16] + ch1[15:8] + ch1[7:0]
        + ch2[23:16] + ch2[15:8] + ch2[7:0] + flags;
    return sum;
  endfunction

endpackage

// File: rtl/adc_result_framer_if.sv
// Result-capture inputs and the outgoing byte stream of the ADC result framer.
interface adc_result_framer_if #(
  parameter int unsigned DATA_WIDTH = 18
);

  logic                  result_valid;
  logic                  result_diap;
  logic [DATA_WIDTH-1:0] data_in_1;
  logic [DATA_WIDTH-1:0] data_in_2;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  // Framer side: consumes results, drives the byte stream.
  modport master (
    input  result_valid,
    input  result_diap,
    input  data_in_1,
    input  data_in_2,
    input  tx_ready,
    output tx_data,
    output tx_valid
  );

  // Environment side: acquisition stage plus byte sink.
  modport slave (
    output result_valid,
    output result_diap,
    output data_in_1,
    output data_in_2,
    output tx_ready,
    input  tx_data,
    input  tx_valid
  );

endinterface

// File: rtl/adc_result_framer.sv
// Captures averaged ADC result pairs and serializes each into a 10-byte frame
// on a valid/ready byte stream, with a one-deep pending buffer and sticky overrun.
module adc_result_framer
  import adc_frame_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 18,
  parameter logic [7:0]  HEADER_BYTE = HEADER_BYTE_DFLT
) (
  input  logic                clk,
  input  logic                rst,
  adc_result_framer_if.master bus,
  input  logic                overrun_clr,
  output logic                busy,
  output logic                overrun
);

  state_e      state_q;
  logic [3:0]  idx_q;
  logic [7:0]  seq_q;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;
  logic [23:0] cap_ch1_q, cap_ch2_q;
  logic        cap_diap_q, cap_pend_q, cap_ovr_q;
  logic [7:0]  flags_q, csum_q;
  logic        pend_full_q, pend_diap_q, pend_ovr_q;
  logic [23:0] pend_ch1_q, pend_ch2_q;
  logic        overrun_q;

  logic [23:0] in_ch1, in_ch2;
  logic [3:0]  idx_nxt;
  logic [7:0]  nxt_byte, flags_ld;
  logic        xfer, send_last, pend_take, pend_store, drop;

  // Zero-extend channel inputs to the 24-bit frame fields.
  always_comb begin
    in_ch1 = '0;
    in_ch2 = '0;
    in_ch1[DATA_WIDTH-1:0] = bus.data_in_1;
    in_ch2[DATA_WIDTH-1:0] = bus.data_in_2;
  end

  assign xfer      = tx_valid_q & bus.tx_ready;
  assign send_last = (state_q == StSend) && xfer && (idx_q == IDX_CSUM);
  assign idx_nxt   = idx_q + 4'd1;

  // Pending is consumed when leaving IDLE without a direct result, or at the end of a frame;
  // a result arriving on that same cycle refills the slot instead of being dropped.
  assign pend_take  = pend_full_q && (((state_q == StIdle) && !bus.result_valid) || send_last);
  assign pend_store = bus.result_valid && (state_q != StIdle) && (!pend_full_q || pend_take);
  assign drop       = bus.result_valid && (state_q != StIdle) && pend_full_q && !pend_take;

  // A result that waited in pending reports the overrun status from when it was accepted.
  always_comb begin
    flags_ld            = '0;
    flags_ld[FLAG_DIAP] = cap_diap_q;
    flags_ld[FLAG_OVR]  = cap_pend_q ? cap_ovr_q : overrun_q;
  end

  // Byte to present after the current one transfers.
  always_comb begin
    case (idx_nxt)
      IDX_SEQ:         nxt_byte = seq_q;
      IDX_CH1:         nxt_byte = cap_ch1_q[23:16];
      IDX_CH1 + 4'd1:  nxt_byte = cap_ch1_q[15:8];
      IDX_CH1 + 4'd2:  nxt_byte = cap_ch1_q[7:0];
      IDX_CH2:         nxt_byte = cap_ch2_q[23:16];
      IDX_CH2 + 4'd1:  nxt_byte = cap_ch2_q[15:8];
      IDX_CH2 + 4'd2:  nxt_byte = cap_ch2_q[7:0];
      IDX_FLAGS:       nxt_byte = flags_q;
      IDX_CSUM:        nxt_byte = csum_q;
      default:         nxt_byte = HEADER_BYTE;
    endcase
  end

  // Frame FSM: capture source, build flags/checksum, then stream bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= IDX_HDR;
      seq_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      cap_ch1_q  <= '0;
      cap_ch2_q  <= '0;
      cap_diap_q <= 1'b0;
      cap_pend_q <= 1'b0;
      cap_ovr_q  <= 1'b0;
      flags_q    <= '0;
      csum_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.result_valid) begin
            cap_ch1_q  <= in_ch1;
            cap_ch2_q  <= in_ch2;
            cap_diap_q <= bus.result_diap;
            cap_pend_q <= 1'b0;
            cap_ovr_q  <= 1'b0;
            state_q    <= StLoad;
          end else if (pend_full_q) begin
            cap_ch1_q  <= pend_ch1_q;
            cap_ch2_q  <= pend_ch2_q;
            cap_diap_q <= pend_diap_q;
            cap_pend_q <= 1'b1;
            cap_ovr_q  <= pend_ovr_q;
            state_q    <= StLoad;
          end
        end
        StLoad: begin
          flags_q    <= flags_ld;
          csum_q     <= frame_csum(seq_q, cap_ch1_q, cap_ch2_q, flags_ld);
          idx_q      <= IDX_HDR;
          tx_data_q  <= HEADER_BYTE;
          tx_valid_q <= 1'b1;
          state_q    <= StSend;
        end
        StSend: begin
          if (xfer) begin
            if (idx_q == IDX_CSUM) begin
              seq_q      <= seq_q + 8'd1;
              tx_valid_q <= 1'b0;
              tx_data_q  <= '0;
              if (pend_full_q) begin
                cap_ch1_q  <= pend_ch1_q;
                cap_ch2_q  <= pend_ch2_q;
                cap_diap_q <= pend_diap_q;
                cap_pend_q <= 1'b1;
                cap_ovr_q  <= pend_ovr_q;
                state_q    <= StLoad;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              idx_q     <= idx_nxt;
              tx_data_q <= nxt_byte;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // One-deep pending buffer for results that arrive while a frame is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_full_q <= 1'b0;
      pend_ch1_q  <= '0;
      pend_ch2_q  <= '0;
      pend_diap_q <= 1'b0;
      pend_ovr_q  <= 1'b0;
    end else if (pend_store) begin
      pend_full_q <= 1'b1;
      pend_ch1_q  <= in_ch1;
      pend_ch2_q  <= in_ch2;
      pend_diap_q <= bus.result_diap;
      pend_ovr_q  <= overrun_q;
    end else if (pend_take) begin
      pend_full_q <= 1'b0;
    end
  end

  // Sticky overrun; a drop on the clear cycle wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= drop | (overrun_q & ~overrun_clr);
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign busy         = (state_q != StIdle) || pend_full_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_result_framer.sv
// Self-checking bench for adc_result_framer: byte scoreboard, table of single
// frames, and directed sequences for pending/overrun/reset/seq-wrap cases.
module tb_adc_result_framer;

  logic clk = 1'b0;
  logic rst;
  logic overrun_clr;
  logic busy;
  logic overrun;

  always #5 clk = ~clk;

  adc_result_framer_if #(.DATA_WIDTH(18)) bus ();

  adc_result_framer #(
    .DATA_WIDTH (18),
    .HEADER_BYTE(8'hA5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .overrun_clr(overrun_clr),
    .busy       (busy),
    .overrun    (overrun)
  );

  typedef struct {
    logic [17:0] ch1;
    logic [17:0] ch2;
    logic        diap;
    bit          rnd;
    logic [7:0]  exp_csum;
  } vec_t;

  vec_t       vecs [5];
  logic [7:0] t1_bytes [10];
  logic [7:0] sb [$];
  logic [7:0] exp_seq;
  logic [7:0] last_rx;
  logic [7:0] prev_data;
  bit         prev_stall = 1'b0;
  bit         rnd_ready  = 1'b0;
  int         total      = 0;
  int         bad        = 0;
  int         rx_count   = 0;
  int         base;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected frame built from the frame layout and pushed to the scoreboard.
  task automatic push_frame(input logic [23:0] c1, input logic [23:0] c2,
                            input logic diap, input logic ovr);
    logic [7:0] b [10];
    logic [7:0] sum;
    b[0] = 8'hA5;
    b[1] = exp_seq;
    b[2] = c1[23:16]; b[3] = c1[15:8]; b[4] = c1[7:0];
    b[5] = c2[23:16]; b[6] = c2[15:8]; b[7] = c2[7:0];
    b[8] = {6'd0, ovr, diap};
    sum = 8'd0;
    for (int i = 1; i < 9; i++) sum = sum + b[i];
    b[9] = sum;
    for (int i = 0; i < 10; i++) sb.push_back(b[i]);
    exp_seq = exp_seq + 8'd1;
  endtask

  task automatic strobe(input logic [17:0] c1, input logic [17:0] c2, input logic d);
    @(posedge clk); #1;
    bus.result_valid = 1'b1;
    bus.data_in_1    = c1;
    bus.data_in_2    = c2;
    bus.result_diap  = d;
    @(posedge clk); #1;
    bus.result_valid = 1'b0;
  endtask

  task automatic wait_rx(input int target, input int budget, input string name);
    int n = 0;
    while (rx_count < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check(name, 32'(rx_count >= target), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int  n = 0;
    bit  done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk); #1;
      n++;
      done = (sb.size() == 0) && !busy && !bus.tx_valid;
    end
    check(name, 32'(done), 32'd1);
  endtask

  // Sink ready: constant high, or about 30% high when randomised.
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.tx_ready = rnd_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // Monitor: compare every transferred byte and check hold-during-stall.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(bus.tx_valid), 32'd1);
        check("stall_data", 32'(bus.tx_data), 32'(prev_data));
      end
      if (bus.tx_valid && bus.tx_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_byte actual=%0h required=none (unexpected) at %0t",
                   bus.tx_data, $time);
        end else begin
          check("tx_byte", 32'(bus.tx_data), 32'(sb.pop_front()));
        end
        rx_count++;
        last_rx = bus.tx_data;
      end
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_data  = bus.tx_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst              = 1'b1;
    overrun_clr      = 1'b0;
    bus.result_valid = 1'b0;
    bus.result_diap  = 1'b0;
    bus.data_in_1    = '0;
    bus.data_in_2    = '0;
    exp_seq          = 8'd0;

    t1_bytes = '{8'hA5, 8'h00, 8'h03, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h01, 8'h03};
    vecs[0] = '{ch1: 18'h3FFFF, ch2: 18'h00001, diap: 1'b1, rnd: 1'b1, exp_csum: 8'h04};
    vecs[1] = '{ch1: 18'h00000, ch2: 18'h00000, diap: 1'b0, rnd: 1'b0, exp_csum: 8'h02};
    vecs[2] = '{ch1: 18'h12345, ch2: 18'h2ABCD, diap: 1'b1, rnd: 1'b1, exp_csum: 8'hE7};
    vecs[3] = '{ch1: 18'h3FFFF, ch2: 18'h3FFFF, diap: 1'b0, rnd: 1'b0, exp_csum: 8'h06};
    vecs[4] = '{ch1: 18'h00080, ch2: 18'h10000, diap: 1'b1, rnd: 1'b0, exp_csum: 8'h87};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // Single frame with fixed expected bytes and latency.
    for (int i = 0; i < 10; i++) sb.push_back(t1_bytes[i]);
    exp_seq = 8'd1;
    strobe(18'h3FFFF, 18'h00001, 1'b1);
    @(negedge clk); #1;
    check("lat_load_valid", 32'(bus.tx_valid), 32'd0);
    @(negedge clk); #1;
    check("lat_send_valid", 32'(bus.tx_valid), 32'd1);
    check("lat_header", 32'(bus.tx_data), 32'hA5);
    wait_idle(40, "t1_done");
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_csum", 32'(last_rx), 32'h03);

    // Table of single frames, some with a randomly stalling sink.
    for (int i = 0; i < 5; i++) begin
      rnd_ready = vecs[i].rnd;
      push_frame({6'd0, vecs[i].ch1}, {6'd0, vecs[i].ch2}, vecs[i].diap, 1'b0);
      strobe(vecs[i].ch1, vecs[i].ch2, vecs[i].diap);
      wait_idle(400, "vec_done");
      rnd_ready = 1'b0;
      check("vec_csum", 32'(last_rx), 32'(vecs[i].exp_csum));
    end

    // Three results 3 cycles apart: send, pend, drop.
    base = rx_count;
    push_frame(24'h011111, 24'h022222, 1'b0, 1'b0);
    strobe(18'h11111, 18'h22222, 1'b0);
    @(posedge clk);
    push_frame(24'h00AAAA, 24'h015555, 1'b1, 1'b0);
    strobe(18'h0AAAA, 18'h15555, 1'b1);
    @(posedge clk);
    strobe(18'h00003, 18'h00004, 1'b0);
    wait_rx(base + 10, 30, "t3_a_end");
    @(negedge clk); #1;
    check("t3_b2b_busy", 32'(busy), 32'd1);
    @(negedge clk); #1;
    check("t3_b2b_gap", 32'(rx_count), 32'(base + 11));
    wait_idle(40, "t3_b_done");
    check("t3_ovr_set", 32'(overrun), 32'd1);
    push_frame(24'h000005, 24'h000006, 1'b0, 1'b1);
    strobe(18'h00005, 18'h00006, 1'b0);
    wait_idle(40, "t3_c_done");
    check("t3_ovr_sticky", 32'(overrun), 32'd1);
    @(posedge clk); #1 overrun_clr = 1'b1;
    @(posedge clk); #1 overrun_clr = 1'b0;
    @(negedge clk); #1;
    check("t3_ovr_clr", 32'(overrun), 32'd0);
    push_frame(24'h000007, 24'h000008, 1'b1, 1'b0);
    strobe(18'h00007, 18'h00008, 1'b1);
    wait_idle(40, "t3_d_done");

    // 257 frames: seq covers every value and wraps.
    for (int i = 0; i < 257; i++) begin
      logic [17:0] a, b;
      a = 18'($urandom_range(0, 32'h3FFFF));
      b = 18'($urandom_range(0, 32'h3FFFF));
      push_frame({6'd0, a}, {6'd0, b}, i[0], 1'b0);
      strobe(a, b, i[0]);
      wait_idle(40, "t4_done");
    end

    // Reset mid-frame (byte 4) with pending full.
    base = rx_count;
    push_frame(24'h012345, 24'h006789, 1'b0, 1'b0);
    strobe(18'h12345, 18'h06789, 1'b0);
    @(posedge clk);
    strobe(18'h3AAAA, 18'h05555, 1'b1);
    wait_rx(base + 5, 30, "t5_byte4");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    exp_seq = 8'd0;
    @(negedge clk); #1;
    check("t5_valid_low", 32'(bus.tx_valid), 32'd0);
    check("t5_busy_low", 32'(busy), 32'd0);
    push_frame(24'h000042, 24'h000024, 1'b1, 1'b0);
    strobe(18'h00042, 18'h00024, 1'b1);
    wait_idle(40, "t5_done");
    repeat (20) @(negedge clk);
    #1 check("t5_no_stray", 32'(bus.tx_valid), 32'd0);

    // Result on the cycle byte 9 transfers with pending full.
    base = rx_count;
    push_frame(24'h000101, 24'h000202, 1'b0, 1'b0);
    strobe(18'h00101, 18'h00202, 1'b0);
    @(posedge clk);
    push_frame(24'h000303, 24'h000404, 1'b1, 1'b0);
    strobe(18'h00303, 18'h00404, 1'b1);
    wait_rx(base + 10, 30, "t6_p1_end");
    push_frame(24'h000505, 24'h000606, 1'b0, 1'b0);
    bus.data_in_1    = 18'h00505;
    bus.data_in_2    = 18'h00606;
    bus.result_diap  = 1'b0;
    bus.result_valid = 1'b1;
    @(posedge clk); #1 bus.result_valid = 1'b0;
    wait_idle(80, "t6_done");
    check("t6_overrun", 32'(overrun), 32'd0);
    check("t6_count", 32'(rx_count), 32'(base + 30));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
